// File: rtl/color_correction_matrix_pkg.sv
// Shared constants for the colour correction matrix: default widths,
// coefficient register indices, identity value and frame-state encoding.
// Optional feature macro: CCM_OFFSET_EN (adds R/G/B offset registers 9-11).
package color_correction_matrix_pkg;

  localparam int CCM_DATA_W    = 8;
  localparam int CCM_COEF_W    = 12;
  localparam int CCM_FRAC_BITS = 8;
  localparam int CCM_FCNT_W    = 16;

  localparam int CCM_NUM_COEF  = 9;
  localparam int CCM_NUM_OFF   = 3;

  // Row-major coefficient indices.
  localparam logic [3:0] CCM_RR    = 4'd0;
  localparam logic [3:0] CCM_RG    = 4'd1;
  localparam logic [3:0] CCM_RB    = 4'd2;
  localparam logic [3:0] CCM_GR    = 4'd3;
  localparam logic [3:0] CCM_GG    = 4'd4;
  localparam logic [3:0] CCM_GB    = 4'd5;
  localparam logic [3:0] CCM_BR    = 4'd6;
  localparam logic [3:0] CCM_BG    = 4'd7;
  localparam logic [3:0] CCM_BB    = 4'd8;
  localparam logic [3:0] CCM_OFF_R = 4'd9;
  localparam logic [3:0] CCM_OFF_G = 4'd10;
  localparam logic [3:0] CCM_OFF_B = 4'd11;

  // 1.0 in coefficient units at the default fractional precision.
  localparam logic signed [CCM_COEF_W-1:0] CCM_IDENTITY = CCM_COEF_W'(1 << CCM_FRAC_BITS);

  // Frame-state encoding.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // True for the diagonal entries of the 3x3 matrix.
  function automatic logic is_diag(int idx);
    return (idx == int'(CCM_RR)) || (idx == int'(CCM_GG)) || (idx == int'(CCM_BB));
  endfunction

endpackage

// File: rtl/color_correction_matrix_if.sv
// Pixel, configuration and status bundle for the colour correction matrix.
// master: upstream/software side; slave: the correction block.
// Optional feature macro: CCM_OFFSET_EN (no extra signals, only extra addresses).
interface color_correction_matrix_if
  import color_correction_matrix_pkg::*;
#(
  parameter int DATA_W = CCM_DATA_W,
  parameter int COEF_W = CCM_COEF_W,
  parameter int FCNT_W = CCM_FCNT_W
);

  logic [DATA_W-1:0] iR;
  logic [DATA_W-1:0] iG;
  logic [DATA_W-1:0] iB;
  logic              iValid;
  logic              iDone;

  logic              cfgWe;
  logic [3:0]        cfgAddr;
  logic [COEF_W-1:0] cfgData;
  logic              cfgCommit;

  logic [DATA_W-1:0] oR;
  logic [DATA_W-1:0] oG;
  logic [DATA_W-1:0] oB;
  logic              oValid;
  logic              oDone;
  logic              oPending;
  logic [FCNT_W-1:0] oFrameCnt;

  modport master (
    output iR, iG, iB, iValid, iDone,
    output cfgWe, cfgAddr, cfgData, cfgCommit,
    input  oR, oG, oB, oValid, oDone, oPending, oFrameCnt
  );

  modport slave (
    input  iR, iG, iB, iValid, iDone,
    input  cfgWe, cfgAddr, cfgData, cfgCommit,
    output oR, oG, oB, oValid, oDone, oPending, oFrameCnt
  );

endinterface

// File: rtl/color_correction_matrix_channel.sv
// One output row of the matrix: three signed multiplies, sum with rounding,
// arithmetic shift and clamp to the unsigned pixel range. Three stages.
// Optional feature macro: CCM_OFFSET_EN (adds an integer offset in stage 2).
module ccm_channel
  import color_correction_matrix_pkg::*;
#(
  parameter int DATA_W    = CCM_DATA_W,
  parameter int COEF_W    = CCM_COEF_W,
  parameter int FRAC_BITS = CCM_FRAC_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        r,
  input  logic [DATA_W-1:0]        g,
  input  logic [DATA_W-1:0]        b,
  input  logic signed [COEF_W-1:0] c0,
  input  logic signed [COEF_W-1:0] c1,
  input  logic signed [COEF_W-1:0] c2,
`ifdef CCM_OFFSET_EN
  input  logic signed [COEF_W-1:0] offset,
`endif
  output logic [DATA_W-1:0]        pix
);

  localparam int PROD_W = DATA_W + 1 + COEF_W;
  localparam int SUM_W  = DATA_W + COEF_W + 3;

  localparam logic signed [SUM_W-1:0] ROUND   = SUM_W'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'((1 << DATA_W) - 1);

  logic signed [PROD_W-1:0] p0;
  logic signed [PROD_W-1:0] p1;
  logic signed [PROD_W-1:0] p2;
  logic signed [SUM_W-1:0]  sum_d;
  logic signed [SUM_W-1:0]  sum_q;
  logic signed [SUM_W-1:0]  shifted;
`ifdef CCM_OFFSET_EN
  logic signed [COEF_W-1:0] off_q;
`endif

  // Stage 1: full-precision products; inputs are zero-extended so they stay positive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0 <= '0;
      p1 <= '0;
      p2 <= '0;
    end else begin
      p0 <= PROD_W'($signed({1'b0, r})) * PROD_W'(c0);
      p1 <= PROD_W'($signed({1'b0, g})) * PROD_W'(c1);
      p2 <= PROD_W'($signed({1'b0, b})) * PROD_W'(c2);
    end
  end

`ifdef CCM_OFFSET_EN
  // Offset is captured alongside the products so it comes from the same bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      off_q <= '0;
    end else begin
      off_q <= offset;
    end
  end
`endif

  // Stage 2 combinational sum: products, optional scaled offset, half-LSB rounding.
  always_comb begin
    sum_d = SUM_W'(p0) + SUM_W'(p1) + SUM_W'(p2) + ROUND;
`ifdef CCM_OFFSET_EN
    sum_d = sum_d + (SUM_W'(off_q) <<< FRAC_BITS);
`endif
  end

  // Stage 2 register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign shifted = sum_q >>> FRAC_BITS;

  // Stage 3: clamp the rescaled sum into 0 .. 2^DATA_W-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix <= '0;
    end else if (shifted < 0) begin
      pix <= '0;
    end else if (shifted > PIX_MAX) begin
      pix <= '1;
    end else begin
      pix <= shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/color_correction_matrix.sv
// Colour correction matrix top: double-buffered coefficient banks, frame
// state machine, commit handling, valid/done alignment chain, frame counter
// and three ccm_channel rows.
// Optional feature macro: CCM_OFFSET_EN (R/G/B offsets at addresses 9-11).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | between frames; a pending commit is applied at the next edge
// ST_ACTIVE | frame in progress; commit waits for iDone
module color_correction_matrix
  import color_correction_matrix_pkg::*;
#(
  parameter int DATA_W    = CCM_DATA_W,
  parameter int COEF_W    = CCM_COEF_W,
  parameter int FRAC_BITS = CCM_FRAC_BITS,
  parameter int FCNT_W    = CCM_FCNT_W
) (
  input logic                      clk,
  input logic                      reset,
  color_correction_matrix_if.slave bus
);

`ifdef CCM_OFFSET_EN
  localparam int NREG = CCM_NUM_COEF + CCM_NUM_OFF;
`else
  localparam int NREG = CCM_NUM_COEF;
`endif

  localparam logic [COEF_W-1:0] UNITY = COEF_W'(1 << FRAC_BITS);

  logic [COEF_W-1:0] shadow [NREG];
  logic [COEF_W-1:0] active [NREG];
  logic [NREG-1:0]   wr_hit;
  logic [0:0]        state;
  logic              pending;
  logic              commit_req;
  logic              xfer;
  logic [2:0]        valid_sr;
  logic [2:0]        done_sr;
  logic [FCNT_W-1:0] frame_cnt;

  function automatic logic [COEF_W-1:0] reset_val(int idx);
    return is_diag(idx) ? UNITY : '0;
  endfunction

  // Decode shadow writes and decide whether the bank transfer fires this edge.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NREG; i++) begin
      wr_hit[i] = bus.cfgWe && (bus.cfgAddr == 4'(i));
    end
    commit_req = pending || bus.cfgCommit;
    xfer       = commit_req && ((state == ST_IDLE) || bus.iDone);
  end

  // Shadow takes software writes; active copies shadow (including a same-edge write) on transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        shadow[i] <= reset_val(i);
        active[i] <= reset_val(i);
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_hit[i]) begin
          shadow[i] <= bus.cfgData;
        end
        if (xfer) begin
          active[i] <= wr_hit[i] ? bus.cfgData : shadow[i];
        end
      end
    end
  end

  // Commit request stays pending until the transfer edge clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
    end else begin
      pending <= commit_req && !xfer;
    end
  end

  // Frame state: iDone ends the frame even if a pixel arrives with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (bus.iDone) begin
      state <= ST_IDLE;
    end else if (bus.iValid) begin
      state <= ST_ACTIVE;
    end
  end

  // Valid/done strobes travel alongside the three pixel stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_sr <= '0;
      done_sr  <= '0;
    end else begin
      valid_sr <= {valid_sr[1:0], bus.iValid};
      done_sr  <= {done_sr[1:0], bus.iDone};
    end
  end

  // Count completed frames at the input side; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (bus.iDone) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  ccm_channel #(.DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_BITS(FRAC_BITS)) u_ch_r (
    .clk    (clk),
    .reset  (reset),
    .r      (bus.iR),
    .g      (bus.iG),
    .b      (bus.iB),
    .c0     (active[CCM_RR]),
    .c1     (active[CCM_RG]),
    .c2     (active[CCM_RB]),
`ifdef CCM_OFFSET_EN
    .offset (active[CCM_OFF_R]),
`endif
    .pix    (bus.oR)
  );

  ccm_channel #(.DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_BITS(FRAC_BITS)) u_ch_g (
    .clk    (clk),
    .reset  (reset),
    .r      (bus.iR),
    .g      (bus.iG),
    .b      (bus.iB),
    .c0     (active[CCM_GR]),
    .c1     (active[CCM_GG]),
    .c2     (active[CCM_GB]),
`ifdef CCM_OFFSET_EN
    .offset (active[CCM_OFF_G]),
`endif
    .pix    (bus.oG)
  );

  ccm_channel #(.DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_BITS(FRAC_BITS)) u_ch_b (
    .clk    (clk),
    .reset  (reset),
    .r      (bus.iR),
    .g      (bus.iG),
    .b      (bus.iB),
    .c0     (active[CCM_BR]),
    .c1     (active[CCM_BG]),
    .c2     (active[CCM_BB]),
`ifdef CCM_OFFSET_EN
    .offset (active[CCM_OFF_B]),
`endif
    .pix    (bus.oB)
  );

  assign bus.oValid    = valid_sr[2];
  assign bus.oDone     = done_sr[2];
  assign bus.oPending  = pending;
  assign bus.oFrameCnt = frame_cnt;

endmodule
